// File: rtl/key_schedule_ctrl.sv
// Anubis key-schedule sequencer and 13-entry round-key store.
// Drives the evolution/selection datapath for NR+1 rounds, then serves key reads.
//   clk, reset        : clock, synchronous active-high reset
//   start, encrypt    : begin a schedule run (accepted in IDLE/DONE), mode
//   cipher_key        : user key, latched on an accepted start
//   ks_*              : datapath control (init, key, mode, round, phase, enable)
//   ks_round_key      : selected round key returned by the datapath
//   busy, keys_ready  : run in progress / all round keys stored
//   rk_req, rk_idx    : round-key read request and index
//   rk_valid, rk_data : read response, one cycle after the request
//   rk_err            : rejected read (wrong state or index out of range)
module key_schedule_ctrl #(
    parameter int NR           = 12,
    parameter int ROUND_CYCLES = 16,
    parameter int CAPTURE_AT   = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         encrypt,
    input  logic [127:0] cipher_key,
    output logic         ks_init,
    output logic [127:0] ks_key,
    output logic         ks_encrypt,
    output logic [3:0]   ks_round_num,
    output logic [3:0]   ks_counter,
    output logic         ks_load_key,
    input  logic [127:0] ks_round_key,
    output logic         busy,
    output logic         keys_ready,
    input  logic         rk_req,
    input  logic [3:0]   rk_idx,
    output logic         rk_valid,
    output logic [127:0] rk_data,
    output logic         rk_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] LAST_CNT = 4'(ROUND_CYCLES - 1);
    localparam logic [3:0] CAP_CNT  = 4'(CAPTURE_AT);
    localparam logic [3:0] LAST_RND = 4'(NR);

    logic [1:0]   state;
    logic [127:0] key_buf [0:NR];

    logic is_idle;
    logic is_load;
    logic is_run;
    logic is_done;
    logic accept;
    logic rd_ok;

    assign is_idle = (state == S_IDLE);
    assign is_load = (state == S_LOAD);
    assign is_run  = (state == S_RUN);
    assign is_done = (state == S_DONE);

    assign accept = start && (is_idle || is_done);

    // A start in DONE takes priority over a read on the same cycle.
    assign rd_ok = rk_req && is_done && !start && (rk_idx <= LAST_RND);

    assign ks_init     = is_load;
    assign ks_load_key = is_run;
    assign busy        = is_load || is_run;
    assign keys_ready  = is_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            ks_key       <= '0;
            ks_encrypt   <= 1'b0;
            ks_round_num <= '0;
            ks_counter   <= '0;
            rk_valid     <= 1'b0;
            rk_err       <= 1'b0;
            rk_data      <= '0;
        end else begin
            rk_valid <= rd_ok;
            rk_err   <= rk_req && !rd_ok;
            if (rd_ok) begin
                rk_data <= key_buf[rk_idx];
            end

            unique case (1'b1)
                is_idle || is_done: begin
                    if (accept) begin
                        ks_key       <= cipher_key;
                        ks_encrypt   <= encrypt;
                        ks_round_num <= '0;
                        ks_counter   <= '0;
                        state        <= S_LOAD;
                    end
                end
                is_load: begin
                    state <= S_RUN;
                end
                is_run: begin
                    if (ks_counter == LAST_CNT) begin
                        ks_counter <= '0;
                        if (ks_round_num == LAST_RND) begin
                            ks_round_num <= '0;
                            state        <= S_DONE;
                        end else begin
                            ks_round_num <= ks_round_num + 4'd1;
                        end
                    end else begin
                        ks_counter <= ks_counter + 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Key store has no reset; contents only become meaningful once DONE.
    always_ff @(posedge clk) begin
        if (!reset && is_run && (ks_counter == CAP_CNT)) begin
            key_buf[ks_round_num] <= ks_round_key;
        end
    end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl with a behavioural datapath stub.
// A cycle-count model predicts every output; literal checks pin key timings.
module tb_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         encrypt;
    logic [127:0] cipher_key;
    logic         ks_init;
    logic [127:0] ks_key;
    logic         ks_encrypt;
    logic [3:0]   ks_round_num;
    logic [3:0]   ks_counter;
    logic         ks_load_key;
    logic [127:0] ks_round_key;
    logic         busy;
    logic         keys_ready;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic         rk_err;

    key_schedule_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .encrypt      (encrypt),
        .cipher_key   (cipher_key),
        .ks_init      (ks_init),
        .ks_key       (ks_key),
        .ks_encrypt   (ks_encrypt),
        .ks_round_num (ks_round_num),
        .ks_counter   (ks_counter),
        .ks_load_key  (ks_load_key),
        .ks_round_key (ks_round_key),
        .busy         (busy),
        .keys_ready   (keys_ready),
        .rk_req       (rk_req),
        .rk_idx       (rk_idx),
        .rk_valid     (rk_valid),
        .rk_data      (rk_data),
        .rk_err       (rk_err)
    );

    always #5 clk = ~clk;

    assign ks_round_key = {32{ks_round_num}};

    localparam logic [127:0] K0 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] K2 = 128'hDEADBEEF0123456789ABCDEFFEEDF00D;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=idle 1=busy 2=done; m_t = edges since accept.
    int           m_mode  = 0;
    int           m_t     = 0;
    logic [127:0] m_key   = '0;
    logic         m_enc   = 1'b0;
    logic         m_valid = 1'b0;
    logic         m_err   = 1'b0;
    logic [127:0] m_data  = '0;
    bit           chk_en  = 1'b0;
    int           cyc     = 0;
    int           busy_cnt = 0;
    int           init_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_mode = 0; m_t = 0; m_key = '0; m_enc = 1'b0;
            m_valid = 1'b0; m_err = 1'b0; m_data = '0;
        end else begin
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (rk_req) begin
                if (m_mode == 2 && !start && rk_idx <= 4'd12) begin
                    m_valid = 1'b1;
                    m_data  = {32{rk_idx}};
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_mode != 1 && start) begin
                m_mode = 1; m_t = 1; m_key = cipher_key; m_enc = encrypt;
            end else if (m_mode == 1) begin
                m_t++;
                if (m_t > 209) begin
                    m_mode = 2;
                    m_t    = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (ks_init === 1'b1) init_cnt++;
        if (chk_en) begin
            logic e_load;
            int   k;
            e_load = (m_mode == 1) && (m_t >= 2);
            k = e_load ? (m_t - 2) : 0;
            check("ks_init", ks_init, (m_mode == 1) && (m_t == 1));
            check("ks_load_key", ks_load_key, e_load);
            check("busy", busy, m_mode == 1);
            check("keys_ready", keys_ready, m_mode == 2);
            check("ks_round_num", ks_round_num, k / 16);
            check("ks_counter", ks_counter, k % 16);
            check("ks_key", ks_key, m_key);
            check("ks_encrypt", ks_encrypt, m_enc);
            check("rk_valid", rk_valid, m_valid);
            check("rk_err", rk_err, m_err);
            check("rk_data", rk_data, m_data);
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Returns at the negedge following the accepting edge; c0 = that edge.
    task automatic do_start(input logic enc, input logic [127:0] k,
                            output int c0);
        busy_cnt   = 0;
        init_cnt   = 0;
        start      = 1'b1;
        encrypt    = enc;
        cipher_key = k;
        tick();
        c0         = cyc;
        start      = 1'b0;
        encrypt    = ~enc;
        cipher_key = rnd128();
    endtask

    task automatic wait_ready(input int c0, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (keys_ready === 1'b1) break;
            tick();
        end
        check({tag, "_ready"}, keys_ready, 1'b1);
        check({tag, "_latency"}, cyc - c0, 209);
        check({tag, "_busy_cycles"}, busy_cnt, 209);
        check({tag, "_init_cycles"}, init_cnt, 1);
    endtask

    initial begin
        int c0;
        reset = 1'b1; start = 1'b0; encrypt = 1'b0; cipher_key = '0;
        rk_req = 1'b0; rk_idx = '0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_ks_key", ks_key, 128'h0);
        check("rst_rk_data", rk_data, 128'h0);
        reset = 1'b0;
        tick();

        // First run, with an early rejected read and an ignored start.
        do_start(1'b1, K0, c0);
        check("load_init", ks_init, 1'b1);
        check("load_key", ks_key, K0);
        repeat (4) tick();
        rk_req = 1'b1; rk_idx = 4'd3;
        tick();
        rk_req = 1'b0;
        check("run_read_err", rk_err, 1'b1);
        check("run_read_valid", rk_valid, 1'b0);
        repeat (45) tick();
        start = 1'b1; encrypt = 1'b0; cipher_key = K2;
        tick();
        start = 1'b0;
        check("ign_start_enc", ks_encrypt, 1'b1);
        check("ign_start_key", ks_key, K0);
        wait_ready(c0, "run1");

        // Back-to-back reads of every round key.
        rk_req = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            rk_idx = 4'(i);
            tick();
            check("rd_valid", rk_valid, 1'b1);
            check("rd_data", rk_data, {32{4'(i)}});
        end
        check("rd_data_12", rk_data, 128'hCCCCCCCCCCCCCCCCCCCCCCCCCCCCCCCC);
        rk_idx = 4'd13;
        tick();
        rk_req = 1'b0;
        check("oob_err", rk_err, 1'b1);
        check("oob_valid", rk_valid, 1'b0);
        check("oob_data_hold", rk_data, 128'hCCCCCCCCCCCCCCCCCCCCCCCCCCCCCCCC);

        // Random reads in DONE.
        for (int i = 0; i < 40; i++) begin
            rk_req = 1'($urandom_range(0, 1));
            rk_idx = 4'($urandom_range(0, 15));
            tick();
        end
        rk_req = 1'b0;
        tick();

        // Reset in the middle of round 6, then a clean run.
        do_start(1'b1, rnd128(), c0);
        repeat (100) tick();
        check("mid_round", ks_round_num, 4'd6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", keys_ready, 1'b0);
        check("mid_rst_round", ks_round_num, 4'd0);
        tick();
        do_start(1'b1, K0, c0);
        wait_ready(c0, "run2");

        // Start and read together in DONE: start wins.
        busy_cnt = 0;
        init_cnt = 0;
        start = 1'b1; encrypt = 1'b0; cipher_key = K2;
        rk_req = 1'b1; rk_idx = 4'd5;
        tick();
        c0 = cyc;
        start = 1'b0; rk_req = 1'b0;
        check("coll_err", rk_err, 1'b1);
        check("coll_valid", rk_valid, 1'b0);
        check("coll_ready", keys_ready, 1'b0);
        check("coll_init", ks_init, 1'b1);
        wait_ready(c0, "run3");
        check("run3_enc", ks_encrypt, 1'b0);
        check("run3_key", ks_key, K2);

        // Fully random traffic; model tracks acceptance and reads.
        for (int i = 0; i < 600; i++) begin
            start      = ($urandom_range(0, 15) == 0);
            encrypt    = 1'($urandom_range(0, 1));
            cipher_key = rnd128();
            rk_req     = 1'($urandom_range(0, 1));
            rk_idx     = 4'($urandom_range(0, 15));
            tick();
        end
        start = 1'b0; rk_req = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
